// File: rtl/pixel_writeback_pkg.sv
// Shared definitions for the pixel write-back slice.
// Holds the FSM state encoding, the memory plane-select constants, the
// address/colour/depth widths, the queued pixel record layout and the
// framebuffer address helper used by pixel_writeback.
package pixel_writeback_pkg;

  localparam int ADDR_W  = 19;
  localparam int COLOR_W = 16;
  localparam int DEPTH_W = 2;
  localparam int COORD_W = 16;
  localparam int ENTRY_W = 2 * COORD_W + DEPTH_W + COLOR_W;

  localparam logic PLANE_COLOR = 1'b0;
  localparam logic PLANE_DEPTH = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_DEPTH_RD,
    ST_COLOR_WR,
    ST_DEPTH_WR,
    ST_DONE
  } wb_state_t;

  // Queue entry layout: {x, y, depth, color}, 50 bits.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [DEPTH_W-1:0] depth;
    logic [COLOR_W-1:0] color;
  } pixel_t;

  // Linear framebuffer address y*width + x, truncated to the 19-bit bus.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y,
                                                   input int unsigned width);
    return ADDR_W'(y) * ADDR_W'(width) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_writeback_fifo.sv
// pixel_fifo: circular pixel queue in front of the write-back FSM.
// Ports:
//   clock, in_reset_n      - clock, synchronous active-low reset
//   in_push, in_data       - enqueue request and entry (ignored when full)
//   in_pop                 - dequeue request (ignored when empty)
//   out_data               - head entry (valid while not empty)
//   out_full, out_empty    - occupancy flags, derived from registered count
// FIFO_DEPTH must be a power of two so the pointers wrap for free.
module pixel_fifo #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ENTRY_W    = 50
) (
  input  logic               clock,
  input  logic               in_reset_n,
  input  logic               in_push,
  input  logic [ENTRY_W-1:0] in_data,
  input  logic               in_pop,
  output logic [ENTRY_W-1:0] out_data,
  output logic               out_full,
  output logic               out_empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [ENTRY_W-1:0] entries [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               push_ok;
  logic               pop_ok;

  assign out_full  = (count == (PTR_W + 1)'(FIFO_DEPTH));
  assign out_empty = (count == '0);
  assign push_ok   = in_push && !out_full;
  assign pop_ok    = in_pop && !out_empty;
  assign out_data  = entries[rd_ptr];

  always_ff @(posedge clock) begin
    if (!in_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop_ok};
    end
  end

  // Storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) entries[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/pixel_writeback.sv
// pixel_writeback: drains rasterizer pixels from a small queue into the
// framebuffer over a req/ack memory port, optionally depth-testing first.
// Optional feature macro: PIXEL_WRITEBACK_DEPTH_TEST_EN
//   defined   -> depth read, compare, colour write, depth write per pixel
//   undefined -> colour write only; out_mem_sel stays 0, in_mem_rdata unused
// Ports:
//   clock, in_reset_n            - clock, synchronous active-low reset
//   in_sig_write_pixel, in_pixel_x/_y/_depth/_color - pixel strobe and data
//   in_sig_rasterize_done        - end-of-triangle pulse (latched sticky)
//   out_sig_stall                - queue full, upstream must hold its pixel
//   out_mem_req/_we/_sel/_addr/_wdata, in_mem_ack, in_mem_rdata - memory port
//   out_sig_frame_done           - single-cycle completion pulse
//   out_pixels_written           - committed colour writes (wraps)
module pixel_writeback
  import pixel_writeback_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FB_WIDTH   = 640,
  parameter int unsigned FB_HEIGHT  = 480
) (
  input  logic        clock,
  input  logic        in_reset_n,
  input  logic        in_sig_write_pixel,
  input  logic [15:0] in_pixel_x,
  input  logic [15:0] in_pixel_y,
  input  logic [1:0]  in_pixel_depth,
  input  logic [15:0] in_pixel_color,
  input  logic        in_sig_rasterize_done,
  output logic        out_sig_stall,
  output logic        out_mem_req,
  output logic        out_mem_we,
  output logic        out_mem_sel,
  output logic [18:0] out_mem_addr,
  output logic [15:0] out_mem_wdata,
  input  logic        in_mem_ack,
  input  logic [15:0] in_mem_rdata,
  output logic        out_sig_frame_done,
  output logic [15:0] out_pixels_written
);

  wb_state_t          state;
  wb_state_t          state_next;
  pixel_t             head;
  logic [ENTRY_W-1:0] head_raw;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               in_range;
  logic               ack_seen;
  logic               done_pending;
  logic [COLOR_W-1:0] work_color;
  logic               issue;
  logic               issue_we;
  logic               issue_sel;
  logic [COLOR_W-1:0] issue_wdata;

  pixel_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ENTRY_W    (ENTRY_W)
  ) u_fifo (
    .clock      (clock),
    .in_reset_n (in_reset_n),
    .in_push    (in_sig_write_pixel),
    .in_data    ({in_pixel_x, in_pixel_y, in_pixel_depth, in_pixel_color}),
    .in_pop     (pop),
    .out_data   (head_raw),
    .out_full   (fifo_full),
    .out_empty  (fifo_empty)
  );

  assign head          = head_raw;
  assign push          = in_sig_write_pixel && !fifo_full;
  assign out_sig_stall = fifo_full;
  assign in_range      = (32'(head.x) < FB_WIDTH) && (32'(head.y) < FB_HEIGHT);
  // An ack only counts while a request is outstanding.
  assign ack_seen      = out_mem_req && in_mem_ack;
  assign out_sig_frame_done = (state == ST_DONE);

`ifdef PIXEL_WRITEBACK_DEPTH_TEST_EN
  logic [DEPTH_W-1:0]         work_depth;
  logic                       depth_pass;
  logic [COLOR_W-DEPTH_W-1:0] unused_rdata_hi;
  // Smaller depth is nearer; equal depth still wins.
  assign depth_pass      = (work_depth <= in_mem_rdata[DEPTH_W-1:0]);
  assign unused_rdata_hi = in_mem_rdata[COLOR_W-1:DEPTH_W];
`else
  logic [COLOR_W-1:0] unused_rdata;
  logic [DEPTH_W-1:0] unused_depth;
  assign unused_rdata = in_mem_rdata;
  assign unused_depth = head.depth;
`endif

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    issue       = 1'b0;
    issue_we    = 1'b0;
    issue_sel   = PLANE_COLOR;
    issue_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_next = ST_POP;
        end else if (done_pending && !push) begin
          state_next = ST_DONE;
        end
      end
      ST_POP: begin
        pop = 1'b1;
        if (!in_range) begin
          state_next = ST_IDLE;
        end else begin
          // First request goes out on this edge to keep push->req at 3 cycles.
          issue = 1'b1;
`ifdef PIXEL_WRITEBACK_DEPTH_TEST_EN
          state_next = ST_DEPTH_RD;
          issue_sel  = PLANE_DEPTH;
`else
          state_next  = ST_COLOR_WR;
          issue_we    = 1'b1;
          issue_wdata = head.color;
`endif
        end
      end
`ifdef PIXEL_WRITEBACK_DEPTH_TEST_EN
      ST_DEPTH_RD: begin
        if (ack_seen) state_next = depth_pass ? ST_COLOR_WR : ST_IDLE;
      end
      ST_DEPTH_WR: begin
        if (ack_seen) begin
          state_next = ST_IDLE;
        end else if (!out_mem_req) begin
          issue       = 1'b1;
          issue_we    = 1'b1;
          issue_sel   = PLANE_DEPTH;
          issue_wdata = {{(COLOR_W - DEPTH_W){1'b0}}, work_depth};
        end
      end
`endif
      ST_COLOR_WR: begin
        if (ack_seen) begin
`ifdef PIXEL_WRITEBACK_DEPTH_TEST_EN
          state_next = ST_DEPTH_WR;
`else
          state_next = ST_IDLE;
`endif
        end else if (!out_mem_req) begin
          // Entered after a completed read: req spent one cycle low.
          issue       = 1'b1;
          issue_we    = 1'b1;
          issue_wdata = work_color;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!in_reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!in_reset_n) begin
      done_pending       <= 1'b0;
      out_pixels_written <= '0;
      out_mem_req        <= 1'b0;
      out_mem_we         <= 1'b0;
      out_mem_sel        <= PLANE_COLOR;
      out_mem_addr       <= '0;
      out_mem_wdata      <= '0;
    end else begin
      // A done pulse landing in DONE itself belongs to the next frame.
      if (state == ST_DONE) begin
        done_pending <= in_sig_rasterize_done;
      end else if (in_sig_rasterize_done) begin
        done_pending <= 1'b1;
      end

      if (ack_seen) begin
        out_mem_req <= 1'b0;
      end else if (issue) begin
        out_mem_req   <= 1'b1;
        out_mem_we    <= issue_we;
        out_mem_sel   <= issue_sel;
        out_mem_wdata <= issue_wdata;
        if (state == ST_POP) out_mem_addr <= pixel_addr(head.x, head.y, FB_WIDTH);
      end

      if (ack_seen && (state == ST_COLOR_WR)) begin
        out_pixels_written <= out_pixels_written + 16'd1;
      end
    end
  end

  // Working copy of the popped pixel, held for the later write phases.
  always_ff @(posedge clock) begin
    if (state == ST_POP) begin
      work_color <= head.color;
`ifdef PIXEL_WRITEBACK_DEPTH_TEST_EN
      work_depth <= head.depth;
`endif
    end
  end

endmodule

// File: tb/tb_pixel_writeback.sv
`timescale 1ns/1ps
module tb_pixel_writeback;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FB_WIDTH   = 640;
  localparam int unsigned FB_HEIGHT  = 480;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        write_pixel;
  logic [15:0] pixel_x, pixel_y, pixel_color;
  logic [1:0]  pixel_depth;
  logic        rast_done;
  logic        stall, mem_req, mem_we, mem_sel, frame_done;
  logic [18:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata, pixels_written;
  logic        resp_ack = 1'b0;
  logic        force_ack;
  logic        mem_ack;
  assign mem_ack = resp_ack | force_ack;

  pixel_writeback #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FB_WIDTH   (FB_WIDTH),
    .FB_HEIGHT  (FB_HEIGHT)
  ) dut (
    .clock                 (clock),
    .in_reset_n            (reset_n),
    .in_sig_write_pixel    (write_pixel),
    .in_pixel_x            (pixel_x),
    .in_pixel_y            (pixel_y),
    .in_pixel_depth        (pixel_depth),
    .in_pixel_color        (pixel_color),
    .in_sig_rasterize_done (rast_done),
    .out_sig_stall         (stall),
    .out_mem_req           (mem_req),
    .out_mem_we            (mem_we),
    .out_mem_sel           (mem_sel),
    .out_mem_addr          (mem_addr),
    .out_mem_wdata         (mem_wdata),
    .in_mem_ack            (mem_ack),
    .in_mem_rdata          (mem_rdata),
    .out_sig_frame_done    (frame_done),
    .out_pixels_written    (pixels_written)
  );

  always #5 clock = ~clock;

  typedef struct {
    int x; int y; int d; int color; bit in_range; int addr;
  } pix_t;

  typedef struct {
    int x; int y; int d; int color; int rdata; bit in_range; int addr;
  } vec_t;

  typedef struct {
    logic we; logic sel; logic [18:0] addr; logic [15:0] wdata; logic [15:0] rdata;
  } txn_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  txn_t        log_q[$];
  pix_t        plist[$];
  logic [15:0] exp_written = 16'd0;

  // Memory responder controls
  bit          resp_en = 1'b0;
  bit          rand_delay = 1'b0;
  bit          rand_rdata = 1'b0;
  int          rd_delay = 0, wr_delay = 0, cur_delay = 0, wait_cnt = 0;
  logic [15:0] fixed_rdata = 16'd0;
  txn_t        first_t, ack_t;
  int          last_ack_cyc = 0;
  int          fd_count = 0, fd_cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Responds to each request after a programmable number of cycles and logs it.
  always @(negedge clock) begin
    if (!resp_en || resp_ack) begin
      resp_ack = 1'b0;
      wait_cnt = 0;
    end else if (mem_req) begin
      if (wait_cnt == 0) begin
        first_t.we = mem_we; first_t.sel = mem_sel;
        first_t.addr = mem_addr; first_t.wdata = mem_wdata;
        cur_delay = rand_delay ? int'($urandom_range(0, 3)) : (mem_we ? wr_delay : rd_delay);
      end
      if (wait_cnt >= cur_delay) begin
        ack_t.we = mem_we; ack_t.sel = mem_sel; ack_t.addr = mem_addr; ack_t.wdata = mem_wdata;
        ack_t.rdata = rand_rdata ? 16'($urandom) : fixed_rdata;
        if (wait_cnt > 0)
          check("req_fields_held", {ack_t.we, ack_t.sel, ack_t.addr, ack_t.wdata},
                {first_t.we, first_t.sel, first_t.addr, first_t.wdata});
        mem_rdata = ack_t.rdata;
        resp_ack = 1'b1;
        log_q.push_back(ack_t);
        last_ack_cyc = cyc;
      end else begin
        wait_cnt++;
      end
    end
  end

  always @(negedge clock) begin
    if (frame_done === 1'b1) begin
      fd_count++;
      fd_cyc = cyc;
    end
  end

  function automatic pix_t mk_pix(input int x, input int y, input int d, input int c);
    pix_t p;
    p.x = x; p.y = y; p.d = d; p.color = c;
    p.in_range = (x < int'(FB_WIDTH)) && (y < int'(FB_HEIGHT));
    p.addr = y * int'(FB_WIDTH) + x;
    return p;
  endfunction

  task automatic drive_pix(input pix_t p);
    pixel_x = 16'(p.x); pixel_y = 16'(p.y);
    pixel_depth = 2'(p.d); pixel_color = 16'(p.color);
  endtask

  task automatic push_pixel(input pix_t p);
    @(negedge clock);
    drive_pix(p);
    write_pixel = 1'b1;
    @(posedge clock);
    #1 write_pixel = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int q = 0;
    int n = 0;
    while (q < 8 && n < budget) begin
      @(negedge clock);
      n++;
      q = mem_req ? 0 : q + 1;
    end
    check({tag, "_drained"}, longint'(q >= 8), 1);
  endtask

  task automatic expect_txn(input string tag, input int idx, input bit we, input bit sel,
                            input int addr, input int wdata);
    check($sformatf("%s_txn%0d_present", tag, idx), longint'(log_q.size() > idx), 1);
    if (log_q.size() > idx)
      check($sformatf("%s_txn%0d", tag, idx),
            {log_q[idx].we, log_q[idx].sel, log_q[idx].addr, log_q[idx].wdata},
            {we, sel, 19'(addr), 16'(wdata)});
  endtask

  // Expected memory traffic for an ordered list of accepted pixels.
  task automatic check_stream(input string tag);
    int li = 0;
    int rd;
    foreach (plist[i]) begin
      if (!plist[i].in_range) continue;
`ifdef PIXEL_WRITEBACK_DEPTH_TEST_EN
      expect_txn(tag, li, 1'b0, 1'b1, plist[i].addr, 0);
      rd = (log_q.size() > li) ? int'(log_q[li].rdata[1:0]) : 0;
      li++;
      if (plist[i].d <= rd) begin
        expect_txn(tag, li, 1'b1, 1'b0, plist[i].addr, plist[i].color);
        li++;
        exp_written = exp_written + 16'd1;
        expect_txn(tag, li, 1'b1, 1'b1, plist[i].addr, plist[i].d);
        li++;
      end
`else
      rd = 0;
      expect_txn(tag, li, 1'b1, 1'b0, plist[i].addr, plist[i].color + rd);
      li++;
      exp_written = exp_written + 16'd1;
`endif
    end
    check({tag, "_txn_count"}, log_q.size(), li);
    check({tag, "_written"}, pixels_written, exp_written);
  endtask

  vec_t vecs[8];
  int   lat, acc, guard, fd0, seen;
  bit   found;
  pix_t p;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual running, required finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; write_pixel = 1'b0; rast_done = 1'b0; force_ack = 1'b0;
    pixel_x = '0; pixel_y = '0; pixel_depth = '0; pixel_color = '0; mem_rdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_sel", mem_sel, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_stall", stall, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_written", pixels_written, 0);
    reset_n = 1'b1;
    resp_en = 1'b1; rd_delay = 2; wr_delay = 2;

    // x, y, depth, color, rdata, in_range, expected address
    vecs[0] = '{100, 25, 0, 'hFF00, 3, 1'b1, 16100};
    vecs[1] = '{103, 29, 2, 'h1234, 1, 1'b1, 18663};
    vecs[2] = '{640, 10, 0, 'h0F0F, 3, 1'b0, 0};
    vecs[3] = '{5, 480, 0, 'hF0F0, 3, 1'b0, 0};
    vecs[4] = '{0, 0, 3, 'hABCD, 3, 1'b1, 0};
    vecs[5] = '{639, 479, 1, 'h7777, 0, 1'b1, 307199};
    vecs[6] = '{639, 0, 2, 'h8001, 2, 1'b1, 639};
    vecs[7] = '{0, 479, 0, 'h4321, 0, 1'b1, 306560};

    foreach (vecs[i]) begin
      log_q.delete(); plist.delete();
      fixed_rdata = 16'(vecs[i].rdata);
      p.x = vecs[i].x; p.y = vecs[i].y; p.d = vecs[i].d; p.color = vecs[i].color;
      p.in_range = vecs[i].in_range; p.addr = vecs[i].addr;
      plist.push_back(p);
      push_pixel(p);
      if (vecs[i].in_range) begin
        lat = 0;
        do begin
          @(negedge clock);
          lat++;
        end while (!mem_req && lat < 10);
        check($sformatf("vec%0d_latency", i), lat, 3);
      end
      wait_quiet($sformatf("vec%0d", i), 300);
      check_stream($sformatf("vec%0d", i));
    end

    // Queue fills while the FSM is held busy by a slow memory.
    log_q.delete(); plist.delete();
    rd_delay = 20; wr_delay = 20; fixed_rdata = 16'd3;
    p = mk_pix(10, 10, 0, 'hAAAA);
    plist.push_back(p);
    push_pixel(p);
    seen = 0;
    while (!mem_req && seen < 10) begin
      @(negedge clock);
      seen++;
    end
    check("busy_req_seen", mem_req, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check($sformatf("stall_before_strobe%0d", i), stall, longint'(i >= 4));
      p = mk_pix(200 + i, 50 + i, i % 4, 'h1000 + i);
      if (i < 4) plist.push_back(p);
      drive_pix(p);
      write_pixel = 1'b1;
    end
    @(negedge clock);
    write_pixel = 1'b0;
    check("stall_after_burst", stall, 1);
    wait_quiet("burst", 2000);
    check_stream("burst");

    // Frame completion with two pixels outstanding.
    log_q.delete(); plist.delete();
    rd_delay = 1; wr_delay = 1; fixed_rdata = 16'd3;
    fd0 = fd_count;
    p = mk_pix(1, 2, 1, 'h0123);
    plist.push_back(p);
    @(negedge clock); drive_pix(p); write_pixel = 1'b1;
    p = mk_pix(3, 4, 2, 'h0456);
    plist.push_back(p);
    @(negedge clock); drive_pix(p); rast_done = 1'b1;
    @(negedge clock); write_pixel = 1'b0; rast_done = 1'b0;
    wait_quiet("frame", 300);
    check("frame_done_pulses", fd_count - fd0, 1);
    check("frame_done_timing", fd_cyc - last_ack_cyc, 2);
    check_stream("frame");

    // Randomized traffic honouring stall, random latencies and read data.
    log_q.delete(); plist.delete();
    rand_delay = 1'b1; rand_rdata = 1'b1;
    acc = 0; guard = 0;
    while (acc < 60 && guard < 5000) begin
      @(negedge clock);
      guard++;
      if (!stall && $urandom_range(0, 2) != 0) begin
        p = mk_pix(int'($urandom_range(0, 719)), int'($urandom_range(0, 529)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
        plist.push_back(p);
        drive_pix(p);
        write_pixel = 1'b1;
        acc++;
      end else begin
        write_pixel = 1'b0;
      end
    end
    @(negedge clock);
    write_pixel = 1'b0;
    check("rand_accepted", acc, 60);
    wait_quiet("rand", 5000);
    check_stream("rand");

    // Reset in the middle of a colour write; a late ack must be ignored.
    log_q.delete(); plist.delete();
    rand_delay = 1'b0; rand_rdata = 1'b0;
    rd_delay = 0; wr_delay = 60; fixed_rdata = 16'd3;
    push_pixel(mk_pix(20, 30, 0, 'h5555));
    push_pixel(mk_pix(21, 30, 0, 'h6666));
    found = 1'b0; seen = 0;
    while (!found && seen < 40) begin
      @(negedge clock);
      seen++;
      found = mem_req && mem_we && !mem_sel;
    end
    check("reached_color_wr", found, 1);
    resp_en = 1'b0;
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("midrst_req", mem_req, 0);
    check("midrst_stall", stall, 0);
    check("midrst_written", pixels_written, 0);
    check("midrst_frame_done", frame_done, 0);
    reset_n = 1'b1;
    force_ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check($sformatf("late_ack_req%0d", i), mem_req, 0);
    end
    force_ack = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (mem_req) seen++;
    end
    check("post_rst_no_req", seen, 0);
    check("post_rst_written", pixels_written, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_writeback.md
PIXEL_WRITEBACK -- requirements
Module: pixel_writeback

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, pixel queue entries (power of 2, >=2).
REQ-002 SHALL have parameter FB_WIDTH, default 640, framebuffer width in pixels.
REQ-003 SHALL have parameter FB_HEIGHT, default 480, framebuffer height in pixels.
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port in_reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_sig_write_pixel  input  1  pixel valid strobe from rasterizer.
REQ-007 SHALL have ports in_pixel_x, in_pixel_y  input  16 each  screen coordinates.
REQ-008 SHALL have port in_pixel_depth  input  2  pixel depth, 0 = nearest.
REQ-009 SHALL have port in_pixel_color  input  16  ARGB4444 color.
REQ-010 SHALL have port in_sig_rasterize_done  input  1  triangle finished pulse.
REQ-011 SHALL have port out_sig_stall  output  1  queue full; upstream holds pixel.
REQ-012 SHALL have ports out_mem_req, out_mem_we, out_mem_sel  output  1 each  request, write enable, plane (0 color, 1 depth).
REQ-013 SHALL have port out_mem_addr  output  19  pixel address; out_mem_wdata  output  16.
REQ-014 SHALL have ports in_mem_ack  input  1; in_mem_rdata  input  16 (depth in [1:0]).
REQ-015 SHALL have port out_sig_frame_done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port out_pixels_written  output  16  count of color writes committed.

Function
REQ-017 Push: pixel enqueued on rising edge when in_sig_write_pixel=1 and queue not full; strobe while full ignored (no corruption).
REQ-018 out_sig_stall SHALL equal (count==FIFO_DEPTH), registered-state derived, no combinational path from inputs.
REQ-019 Simultaneous push and pop SHALL be legal whenever not full; count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-020 FSM states: IDLE, POP, DEPTH_RD, COLOR_WR, DEPTH_WR, DONE.
REQ-021 IDLE->POP when queue non-empty; POP dequeues one entry into working registers (1 cycle).
REQ-022 POP: x>=FB_WIDTH or y>=FB_HEIGHT -> pixel dropped, back to IDLE; else DEPTH_RD.
REQ-023 Address = y*FB_WIDTH + x, 19-bit, computed in POP, held stable through the transaction.
REQ-024 Memory handshake: out_mem_req, _we, _sel, _addr, _wdata held constant from assertion until the cycle in_mem_ack=1; req deasserts the following cycle; ack without req ignored.
REQ-025 DEPTH_RD: read sel=1; on ack, pass if in_pixel_depth <= in_mem_rdata[1:0] -> COLOR_WR, else IDLE (discard).
REQ-026 COLOR_WR: write sel=1? no: sel=0, wdata=color; on ack increment out_pixels_written (wraps at 16'hFFFF->0) -> DEPTH_WR.
REQ-027 DEPTH_WR: write sel=1, wdata={14'b0,depth}; on ack -> IDLE.
REQ-028 in_sig_rasterize_done SHALL set a sticky done_pending flag (captured even while FSM busy).
REQ-029 IDLE with done_pending=1, queue empty, no push this cycle -> DONE; DONE drives out_sig_frame_done=1 for exactly one cycle, clears done_pending, returns to IDLE.
REQ-030 Minimum latency push->first out_mem_req SHALL be 3 cycles (push, IDLE->POP, POP->DEPTH_RD).

Reset
REQ-031 When in_reset_n=0 at a rising edge: FSM=IDLE, queue empty, done_pending=0, out_pixels_written=0, out_mem_req/_we/_sel=0, out_mem_addr/_wdata=0, out_sig_stall=0, out_sig_frame_done=0.
REQ-032 Reset mid-transaction SHALL abandon it; a late in_mem_ack after reset SHALL be ignored.

Configuration
REQ-033 Macro PIXEL_WRITEBACK_DEPTH_TEST_EN: defined -> DEPTH_RD and DEPTH_WR per REQ-025/027; undefined -> POP goes directly to COLOR_WR, COLOR_WR ack -> IDLE, out_mem_sel always 0, in_mem_rdata unused.

Structure
REQ-034 Shared package SHALL hold state encoding, plane-select constants (PLANE_COLOR=0, PLANE_DEPTH=1), address width 19, color width 16, depth width 2.
REQ-035 Queue SHALL be sub-module pixel_fifo (parameterised depth, 50-bit entry {x,y,depth,color}); FSM and handshake in pixel_writeback.

Verification
REQ-036 Reset, push (100,25,d=0,0xFF00), rdata=3, ack after 2 cycles -> depth read addr 16100, color write 0xFF00 to 16100, depth write 0, count=1.
REQ-037 Push (103,29,d=2), depth read returns 1 -> no color write, count unchanged.
REQ-038 Push 6 pixels back-to-back, ack withheld 20 cycles -> stall high after 4 accepted, 5th/6th strobes dropped, 4 pixels written in order.
REQ-039 Push (640,10) and (5,480) -> no memory request, count 0.
REQ-040 rasterize_done pulsed while 2 pixels queued -> frame_done pulses once, one cycle after last depth write completes.
REQ-041 in_reset_n=0 during COLOR_WR with req high -> next cycle req=0, queue empty, count=0; subsequent ack ignored.
